bcd_stopwatch: RTL
==================

# bcd_stopwatch

Parametrised stopwatch/countdown timer for the FPGA board: debounces the two push-buttons, divides the board clock to a count tick and keeps a DIGITS-wide BCD count, up or down, with pause, lap-freeze and countdown-expiry. It generalises the fixed start/stop timer: configurable clock rate, tick rate, digit count and direction. It feeds the seven-segment display driver, which consumes `disp_bcd`.

## Interface
- `CLK_FREQ`, 50_000_000: board clock frequency, Hz.
- `TICK_HZ`, 100: count rate, Hz. `DIV = CLK_FREQ/TICK_HZ`; must be an integer ≥ 2.
- `DIGITS`, 4: number of BCD digits, 1..8.
- `DEBOUNCE_CYCLES`, 500_000: cycles a synchronised key level must be stable before it is accepted; ≥ 1.

- `clk` in 1: board clock. One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `KEY0` in 1: start/pause button, active-low, asynchronous.
- `KEY1` in 1: clear/lap button, active-low, asynchronous.
- `mode` in 1: 0 = count up, 1 = count down. Sampled only in IDLE.
- `load_val` in 4*DIGITS: BCD countdown start value. Sampled only on clear in IDLE.
- `disp_bcd` out 4*DIGITS: value for the display; digit 0 is in bits [3:0].
- `running` out 1: high in RUN.
- `lap_hold` out 1: high while the display is frozen on a lap value.
- `done` out 1: high in DONE (countdown expired).
- `wrap` out 1: one-cycle pulse when an up-count rolls from all-9s to 0.

## Operation
- Key path: 2-flop synchroniser, inverted to active-high, then a debounce counter. The accepted level changes after `DEBOUNCE_CYCLES` consecutive equal samples. A press event `p0`/`p1` is a one-cycle pulse on the accepted 0→1 edge. Releases generate no event.
- Prescaler: 0..DIV-1. It counts only in RUN, holds its value in PAUSE, and clears on entry to RUN from IDLE. `tick` is high in the cycle the prescaler equals DIV-1.
- Count: DIGITS BCD digits with per-digit carry/borrow. Up: 9→0 carries; all-9s→all-0 asserts `wrap`. Down: 0→9 borrows. The count never holds a non-BCD value. Non-BCD `load_val` digits are loaded as-is, and behaviour is then unspecified.
- `dir` is latched from `mode` on IDLE→RUN.
- State machine, encoded IDLE, RUN, PAUSE, DONE:
  - IDLE:
    - `p0`: if `mode`=1 and the count is 0 → DONE; else → RUN.
    - `p1`: count ← (`mode` ? `load_val` : 0); clear `lap_hold`.
  - RUN:
    - `tick`: count ±1. If `dir`=1 and the count becomes 0 → DONE.
    - `p0`: → PAUSE.
    - `p1`: toggle `lap_hold`. Entering hold captures the current count into `lap_reg`. The count keeps running underneath.
  - PAUSE:
    - `p0`: → RUN, prescaler resumes from its held value.
    - `p1`: → IDLE; count ← (`dir` ? `load_val` : 0); clear `lap_hold`.
  - DONE: count held at 0. `p0` or `p1` → IDLE with count ← `load_val`.
- `disp_bcd` = `lap_hold` ? `lap_reg` : count.
- Simultaneous events:
  - `p0` and `p1` in the same cycle: `p0` is acted on, `p1` is dropped.
  - `tick` and `p0` in the same cycle in RUN: the count update is applied and the state moves to PAUSE.
  - A tick reaching 0 together with `p0`: → DONE, and `p0` is dropped.

## Timing
- Reset values (all in the cycle after `rst` is sampled high):
  - state IDLE; count, `lap_reg` and prescaler 0;
  - `disp_bcd` 0; `running`, `lap_hold`, `done`, `wrap` 0;
  - debounced key levels 0 (released);
  - synchroniser flops 1 (idle-high keys).
- `rst` mid-operation overrides every event in that cycle.
- Key latency: a press stable from cycle t gives a `p` pulse at t + 2 + `DEBOUNCE_CYCLES` (±1). The state and outputs change on the next edge.
- Count latency: the count register updates on the edge after `tick`. `disp_bcd` is registered with the count, so there is no extra cycle.
- First tick after a start from IDLE: DIV cycles after entering RUN. After a resume from PAUSE: DIV minus the already-elapsed prescaler cycles.
- `wrap` is high for exactly one cycle, coincident with the count showing 0.
- `done` is a level, asserted the same edge the count reaches 0.

## Test plan
All scenarios use CLK_FREQ=100, TICK_HZ=10 (DIV=10), DIGITS=2, DEBOUNCE_CYCLES=4.
- Reset then KEY0 pulse low for 10 cycles, mode=0 → `running`=1; `disp_bcd` reaches 8'h01 10 cycles after RUN entry and 8'h10 after 100 cycles.
- Up count from 8'h98 → 8'h99, then 8'h00 with `wrap` high for 1 cycle; `running` stays 1.
- KEY0 press in RUN, held 50 cycles, press again → count frozen during PAUSE; prescaler resumes, so the next tick arrives DIV minus the pre-pause elapsed cycles after the resume.
- mode=1, `load_val`=8'h03, KEY1 in IDLE then KEY0 → count goes 03, 02, 01, 00; `done`=1 and `running`=0 at 00. KEY1 → IDLE with `disp_bcd`=8'h03.
- KEY1 in RUN at count 8'h25 → `lap_hold`=1 and `disp_bcd` stays 8'h25 while the internal count advances. A second KEY1 → the display shows the live count.
- KEY0 and KEY1 bounced (toggling every 2 cycles for 20 cycles) then held low together → exactly one `p0` acted on (→ RUN), no lap/clear; `rst` high for 1 cycle in RUN → all outputs 0, state IDLE.

Source files
------------

// File: rtl/bcd_stopwatch_if.sv
// Signal bundle between the stopwatch and its board-side environment:
// keys, mode and load value in; display value and status flags out.
interface bcd_stopwatch_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  KEY0;
  logic                  KEY1;
  logic                  mode;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic                  running;
  logic                  lap_hold;
  logic                  done;
  logic                  wrap;

  modport master (
    output KEY0, KEY1, mode, load_val,
    input  disp_bcd, running, lap_hold, done, wrap
  );

  modport slave (
    input  KEY0, KEY1, mode, load_val,
    output disp_bcd, running, lap_hold, done, wrap
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// BCD stopwatch / countdown timer: key debounce, tick prescaler, up/down
// BCD counter with pause, lap freeze and countdown expiry.
module bcd_stopwatch #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input logic            clk,
  input logic            rst,
  bcd_stopwatch_if.slave bus
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned W   = 4 * DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  // Key path, index 0 = KEY0 (start/pause), index 1 = KEY1 (clear/lap)
  logic [1:0]         meta;
  logic [1:0]         sync;
  logic [1:0]         raw;
  logic [1:0]         level;
  logic [1:0]         level_q;
  logic [1:0][DW-1:0] dbc;
  logic               p0;
  logic               p1;

  assign raw = ~sync;
  assign p0  = level[0] & ~level_q[0];
  assign p1  = level[1] & ~level_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= '1;
      sync    <= '1;
      level   <= '0;
      level_q <= '0;
      dbc     <= '0;
    end else begin
      meta    <= {bus.KEY1, bus.KEY0};
      sync    <= meta;
      level_q <= level;
      for (int unsigned k = 0; k < 2; k++) begin
        if (raw[k] == level[k]) begin
          dbc[k] <= '0;
        end else if (dbc[k] == DB_LAST) begin
          level[k] <= raw[k];
          dbc[k]   <= '0;
        end else begin
          dbc[k] <= dbc[k] + 1'b1;
        end
      end
    end
  end

  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  lap_reg_q, lap_reg_d;
  logic          lap_hold_q, lap_hold_d;
  logic          dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  inc_val;
  logic          inc_carry;
  logic [W-1:0]  dec_val;
  logic          tick;

  assign {inc_carry, inc_val} = bcd_inc(cnt_q);
  assign dec_val              = bcd_dec(cnt_q);
  assign tick                 = (state_q == RUN) && (presc_q == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lap_reg_q  <= '0;
      lap_hold_q <= 1'b0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lap_reg_q  <= lap_reg_d;
      lap_hold_q <= lap_hold_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      presc_q    <= presc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lap_reg_d  = lap_reg_q;
    lap_hold_d = lap_hold_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    presc_d    = presc_q;
    unique case (state_q)
      IDLE: begin
        if (p0) begin
          if (bus.mode && (cnt_q == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            dir_d   = bus.mode;
            presc_d = '0;
          end
        end else if (p1) begin
          cnt_d      = bus.mode ? bus.load_val : '0;
          lap_hold_d = 1'b0;
        end
      end
      RUN: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        // Expiry on a tick takes priority and swallows any key event.
        if (tick && dir_q && (dec_val == '0)) begin
          cnt_d   = dec_val;
          state_d = DONE;
        end else begin
          if (tick) begin
            if (dir_q) begin
              cnt_d = dec_val;
            end else begin
              cnt_d  = inc_val;
              wrap_d = inc_carry;
            end
          end
          if (p0) begin
            state_d = PAUSE;
          end else if (p1) begin
            lap_hold_d = ~lap_hold_q;
            if (!lap_hold_q) lap_reg_d = cnt_q;
          end
        end
      end
      PAUSE: begin
        if (p0) begin
          state_d = RUN;
        end else if (p1) begin
          state_d    = IDLE;
          cnt_d      = dir_q ? bus.load_val : '0;
          lap_hold_d = 1'b0;
        end
      end
      DONE: begin
        cnt_d = '0;
        if (p0 || p1) begin
          state_d = IDLE;
          cnt_d   = bus.load_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.disp_bcd = lap_hold_q ? lap_reg_q : cnt_q;
  assign bus.running  = (state_q == RUN);
  assign bus.lap_hold = lap_hold_q;
  assign bus.done     = (state_q == DONE);
  assign bus.wrap     = wrap_q;

endmodule
